// File: rtl/lzrw1_pkg.sv
// Shared types for the LZRW1 output packer: item/entry layouts, FSM states, group sizing.
package lzrw1_pkg;

  localparam int CW_BITS   = 16;
  localparam int MAX_GROUP = 16;

  typedef struct packed {
    logic        isCopy;
    logic [7:0]  literal;
    logic [3:0]  length;
    logic [11:0] offset;
  } itemT;

  typedef struct packed {
    logic       isCopy;
    logic [7:0] b0;
    logic [7:0] b1;
  } entryT;

  typedef enum logic [2:0] {
    IDLE,
    COLLECT,
    CW_LO,
    CW_HI,
    DATA
  } stateT;

  // A copy splits into {length, offset[11:8]} then offset[7:0]; a literal uses b0 only.
  function automatic entryT packEntry(input itemT it);
    entryT e;
    e.isCopy = it.isCopy;
    if (it.isCopy) begin
      e.b0 = {it.length, it.offset[11:8]};
      e.b1 = it.offset[7:0];
    end else begin
      e.b0 = it.literal;
      e.b1 = 8'h00;
    end
    return e;
  endfunction

endpackage

// File: rtl/group_buffer.sv
// Register file holding one group of packed entries; single write port, combinational read.
module group_buffer
  import lzrw1_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wrEn,
  input  logic [3:0] wrIdx,
  input  entryT      wrData,
  input  logic [3:0] rdIdx,
  output entryT      rdData
);

  entryT rows [MAX_GROUP];

  genvar gi;
  generate
    for (gi = 0; gi < MAX_GROUP; gi++) begin : gRow
      entryT rowReg;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rowReg <= '0;
        end else if (wrEn && (wrIdx == 4'(gi))) begin
          rowReg <= wrData;
        end
      end

      assign rows[gi] = rowReg;
    end
  endgenerate

  assign rdData = rows[rdIdx];

endmodule

// File: rtl/compressed_stream_packer.sv
// Collects compressor items into LZRW1 groups and serialises each as
// control word (low, high) followed by the item bytes, under backpressure.
module compressed_stream_packer
  import lzrw1_pkg::*;
#(
  parameter int GROUP_ITEMS = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        item_valid,
  output logic        item_ready,
  input  logic        item_is_copy,
  input  logic [7:0]  item_literal,
  input  logic [3:0]  item_length,
  input  logic [11:0] item_offset,
  input  logic        item_last,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_byte,
  output logic        out_last,
  output logic        done
);

  stateT               stateReg, stateNext;
  logic [4:0]          itemCntReg, itemCntNext;
  logic [CW_BITS-1:0]  cwReg, cwNext;
  logic                lastGrpReg, lastGrpNext;
  logic [3:0]          rdIdxReg, rdIdxNext;
  logic                halfReg, halfNext;
  logic                curIsCopyReg, curIsCopyNext;
  logic [7:0]          curB1Reg, curB1Next;
  logic                itemReadyReg, itemReadyNext;
  logic                outValidReg, outValidNext;
  logic [7:0]          outByteReg, outByteNext;
  logic                outLastReg, outLastNext;
  logic                doneReg, doneNext;

  logic  accept;
  logic  fire;
  logic  wrEn;
  logic  isFinalIdx;
  logic  nextIsFinal;
  logic [3:0] rdAddr;
  itemT  inItem;
  entryT wrData;
  entryT rdData;

  assign inItem = '{isCopy: item_is_copy, literal: item_literal,
                    length: item_length, offset: item_offset};
  assign wrData = packEntry(inItem);

  assign accept = item_valid && itemReadyReg;
  assign fire   = outValidReg && out_ready;

  // The read port always points at the entry that will be loaded next, so
  // each output byte is ready in the register on the edge that needs it.
  assign rdAddr      = (stateReg == CW_HI) ? 4'd0 : rdIdxReg + 4'd1;
  assign isFinalIdx  = ({1'b0, rdIdxReg} == itemCntReg - 5'd1);
  assign nextIsFinal = ({1'b0, rdAddr} == itemCntReg - 5'd1);

  group_buffer uBuffer (
    .clk    (clk),
    .rst_n  (rst_n),
    .wrEn   (wrEn),
    .wrIdx  (itemCntReg[3:0]),
    .wrData (wrData),
    .rdIdx  (rdAddr),
    .rdData (rdData)
  );

  always_comb begin
    stateNext     = stateReg;
    itemCntNext   = itemCntReg;
    cwNext        = cwReg;
    lastGrpNext   = lastGrpReg;
    rdIdxNext     = rdIdxReg;
    halfNext      = halfReg;
    curIsCopyNext = curIsCopyReg;
    curB1Next     = curB1Reg;
    outValidNext  = outValidReg;
    outByteNext   = outByteReg;
    outLastNext   = outLastReg;
    doneNext      = 1'b0;
    wrEn          = 1'b0;

    unique case (stateReg)
      IDLE: stateNext = COLLECT;

      COLLECT: begin
        if (accept) begin
          wrEn        = 1'b1;
          cwNext      = cwReg | (CW_BITS'(item_is_copy) << itemCntReg[3:0]);
          itemCntNext = itemCntReg + 5'd1;
          if ((itemCntNext == 5'(GROUP_ITEMS)) || item_last) begin
            stateNext    = CW_LO;
            lastGrpNext  = item_last;
            outValidNext = 1'b1;
            outByteNext  = cwNext[7:0];
            outLastNext  = 1'b0;
          end
        end
      end

      CW_LO: begin
        if (fire) begin
          stateNext   = CW_HI;
          outByteNext = cwReg[15:8];
        end
      end

      CW_HI: begin
        if (fire) begin
          stateNext     = DATA;
          rdIdxNext     = 4'd0;
          halfNext      = 1'b0;
          curIsCopyNext = rdData.isCopy;
          curB1Next     = rdData.b1;
          outByteNext   = rdData.b0;
          outLastNext   = lastGrpReg && nextIsFinal && !rdData.isCopy;
        end
      end

      DATA: begin
        if (fire) begin
          if (curIsCopyReg && !halfReg) begin
            halfNext    = 1'b1;
            outByteNext = curB1Reg;
            outLastNext = lastGrpReg && isFinalIdx;
          end else if (isFinalIdx) begin
            cwNext       = '0;
            itemCntNext  = 5'd0;
            rdIdxNext    = 4'd0;
            halfNext     = 1'b0;
            outValidNext = 1'b0;
            outLastNext  = 1'b0;
            doneNext     = lastGrpReg;
            stateNext    = lastGrpReg ? IDLE : COLLECT;
          end else begin
            rdIdxNext     = rdAddr;
            halfNext      = 1'b0;
            curIsCopyNext = rdData.isCopy;
            curB1Next     = rdData.b1;
            outByteNext   = rdData.b0;
            outLastNext   = lastGrpReg && nextIsFinal && !rdData.isCopy;
          end
        end
      end

      default: stateNext = IDLE;
    endcase

    itemReadyNext = (stateNext == COLLECT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateReg     <= IDLE;
      itemCntReg   <= '0;
      cwReg        <= '0;
      lastGrpReg   <= 1'b0;
      rdIdxReg     <= '0;
      halfReg      <= 1'b0;
      curIsCopyReg <= 1'b0;
      curB1Reg     <= '0;
      itemReadyReg <= 1'b0;
      outValidReg  <= 1'b0;
      outByteReg   <= '0;
      outLastReg   <= 1'b0;
      doneReg      <= 1'b0;
    end else begin
      stateReg     <= stateNext;
      itemCntReg   <= itemCntNext;
      cwReg        <= cwNext;
      lastGrpReg   <= lastGrpNext;
      rdIdxReg     <= rdIdxNext;
      halfReg      <= halfNext;
      curIsCopyReg <= curIsCopyNext;
      curB1Reg     <= curB1Next;
      itemReadyReg <= itemReadyNext;
      outValidReg  <= outValidNext;
      outByteReg   <= outByteNext;
      outLastReg   <= outLastNext;
      doneReg      <= doneNext;
    end
  end

  assign item_ready = itemReadyReg;
  assign out_valid  = outValidReg;
  assign out_byte   = outByteReg;
  assign out_last   = outLastReg;
  assign done       = doneReg;

endmodule

// File: tb/tb_compressed_stream_packer.sv
// Randomised bench for compressed_stream_packer: a queue model of the LZRW1 byte
// stream is checked every accepted output byte, plus literal vectors for directed cases.
module tb_compressed_stream_packer;

  localparam int G = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        item_valid = 1'b0;
  logic        item_ready;
  logic        item_is_copy = 1'b0;
  logic [7:0]  item_literal = '0;
  logic [3:0]  item_length = '0;
  logic [11:0] item_offset = '0;
  logic        item_last = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [7:0]  out_byte;
  logic        out_last;
  logic        done;

  always #5 clk = ~clk;

  compressed_stream_packer #(.GROUP_ITEMS(G)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .item_valid   (item_valid),
    .item_ready   (item_ready),
    .item_is_copy (item_is_copy),
    .item_literal (item_literal),
    .item_length  (item_length),
    .item_offset  (item_offset),
    .item_last    (item_last),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_byte     (out_byte),
    .out_last     (out_last),
    .done         (done)
  );

  int total = 0;
  int bad = 0;
  int doneCount = 0;
  int acceptCount = 0;
  int readyModeG = 2;
  bit checkEn = 1'b0;

  bit itCopy [64];
  int itLit  [64];
  int itLen  [64];
  int itOff  [64];
  bit itLast [64];

  logic [7:0] expByteQ [$];
  bit         expLastQ [$];
  logic [7:0] recQ [$];
  logic [7:0] litQ [$];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  task automatic setLit(input int i, input int v, input bit last);
    itCopy[i] = 1'b0; itLit[i] = v; itLen[i] = 0; itOff[i] = 0; itLast[i] = last;
  endtask

  task automatic setCopy(input int i, input int len, input int off, input bit last);
    itCopy[i] = 1'b1; itLit[i] = 0; itLen[i] = len; itOff[i] = off; itLast[i] = last;
  endtask

  // Reference: split items into groups, then write out cw bytes and item bytes.
  task automatic modelStream(input int n);
    int gStart;
    int cw;
    expByteQ.delete();
    expLastQ.delete();
    gStart = 0;
    for (int i = 0; i < n; i++) begin
      if ((i - gStart + 1 == G) || itLast[i]) begin
        cw = 0;
        for (int k = gStart; k <= i; k++)
          if (itCopy[k]) cw = cw + (1 << (k - gStart));
        expByteQ.push_back(8'(cw % 256)); expLastQ.push_back(1'b0);
        expByteQ.push_back(8'(cw / 256)); expLastQ.push_back(1'b0);
        for (int k = gStart; k <= i; k++) begin
          if (itCopy[k]) begin
            expByteQ.push_back(8'(itLen[k] * 16 + itOff[k] / 256)); expLastQ.push_back(1'b0);
            expByteQ.push_back(8'(itOff[k] % 256));
            expLastQ.push_back(itLast[i] && (k == i));
          end else begin
            expByteQ.push_back(8'(itLit[k]));
            expLastQ.push_back(itLast[i] && (k == i));
          end
        end
        gStart = i + 1;
      end
    end
  endtask

  initial begin : compareProc
    logic       doneExp;
    bit         stallPrev;
    logic [7:0] stallByte;
    logic       stallLast;
    logic [7:0] eb;
    bit         el;
    doneExp = 1'b0;
    stallPrev = 1'b0;
    stallByte = '0;
    stallLast = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n || !checkEn) begin
        doneExp = 1'b0;
        stallPrev = 1'b0;
      end else begin
        check("done_pulse", int'(done), int'(doneExp));
        if (done) doneCount++;
        doneExp = 1'b0;
        if (stallPrev) begin
          check("stall_valid", int'(out_valid), 1);
          check("stall_byte", int'(out_byte), int'(stallByte));
          check("stall_last", int'(out_last), int'(stallLast));
        end
        if (out_valid) check("ready_low_while_emitting", int'(item_ready), 0);
        if (out_valid && out_ready) begin
          acceptCount++;
          if (expByteQ.size() == 0) begin
            check("unexpected_byte", int'(out_byte), 256);
          end else begin
            eb = expByteQ.pop_front();
            el = expLastQ.pop_front();
            check("out_byte", int'(out_byte), int'(eb));
            check("out_last", int'(out_last), int'(el));
            recQ.push_back(out_byte);
            if (el) doneExp = 1'b1;
          end
        end
        stallPrev = out_valid && !out_ready;
        stallByte = out_byte;
        stallLast = out_last;
      end
    end
  end

  initial begin : readyDriver
    forever begin
      @(posedge clk);
      #1;
      if (readyModeG == 0) out_ready = 1'b1;
      else if (readyModeG == 1) out_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "simulation did not finish");
  end

  task automatic sendItem(input int i, input int maxGap);
    int guard;
    repeat ($urandom_range(0, maxGap)) begin @(posedge clk); #1; end
    item_valid   = 1'b1;
    item_is_copy = itCopy[i];
    item_literal = itCopy[i] ? 8'($urandom) : 8'(itLit[i]);
    item_length  = itCopy[i] ? 4'(itLen[i]) : 4'($urandom);
    item_offset  = itCopy[i] ? 12'(itOff[i]) : 12'($urandom);
    item_last    = itLast[i];
    guard = 0;
    forever begin
      @(negedge clk);
      if (item_ready) break;
      guard++;
      if (guard > 3000) begin
        check("item_accept_timeout", 0, 1);
        break;
      end
    end
    @(posedge clk);
    #1;
    item_valid = 1'b0;
    item_last  = 1'b0;
  endtask

  task automatic runStream(input int n, input int mode, input int gap);
    int base;
    int guard;
    modelStream(n);
    recQ.delete();
    readyModeG = mode;
    base = doneCount;
    for (int i = 0; i < n; i++) sendItem(i, gap);
    guard = 0;
    while ((expByteQ.size() != 0 || doneCount == base) && guard < 4000) begin
      @(negedge clk);
      guard++;
    end
    check("drain_timeout", int'(guard < 4000), 1);
    repeat (4) @(negedge clk);
    check("done_count", doneCount - base, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic checkRec(input string name);
    check($sformatf("%s_len", name), recQ.size(), litQ.size());
    for (int i = 0; i < litQ.size() && i < recQ.size(); i++)
      check($sformatf("%s[%0d]", name, i), int'(recQ[i]), int'(litQ[i]));
  endtask

  initial begin : mainProc
    int base;
    int baseAcc;
    int guard;
    int n;

    repeat (3) @(posedge clk);
    #1;
    check("rst_item_ready", int'(item_ready), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_byte", int'(out_byte), 0);
    check("rst_out_last", int'(out_last), 0);
    check("rst_done", int'(done), 0);

    @(negedge clk);
    rst_n = 1'b1;
    checkEn = 1'b1;
    #1;
    check("ready_before_edge", int'(item_ready), 0);
    @(posedge clk);
    #1;
    check("ready_after_edge", int'(item_ready), 1);

    // Empty stream: nothing emitted, no done.
    readyModeG = 0;
    base = doneCount;
    baseAcc = acceptCount;
    repeat (20) @(posedge clk);
    #1;
    check("empty_bytes", acceptCount - baseAcc, 0);
    check("empty_done", doneCount - base, 0);

    setLit(0, 'h41, 0); setLit(1, 'h42, 0); setLit(2, 'h43, 1);
    runStream(3, 0, 0);
    litQ = '{8'h00, 8'h00, 8'h41, 8'h42, 8'h43};
    checkRec("lit3");

    setCopy(0, 2, 'h123, 0); setLit(1, 'h55, 1);
    runStream(2, 0, 0);
    litQ = '{8'h01, 8'h00, 8'h21, 8'h23, 8'h55};
    checkRec("copy_lit");

    for (int i = 0; i < 17; i++) setLit(i, i, i == 16);
    runStream(17, 0, 0);
    litQ.delete();
    litQ.push_back(8'h00); litQ.push_back(8'h00);
    for (int i = 0; i < 16; i++) litQ.push_back(8'(i));
    litQ.push_back(8'h00); litQ.push_back(8'h00); litQ.push_back(8'h10);
    checkRec("lit17");

    for (int i = 0; i < 16; i++) setCopy(i, 'hF, 'hABC, i == 15);
    runStream(16, 0, 0);
    litQ.delete();
    litQ.push_back(8'hFF); litQ.push_back(8'hFF);
    for (int i = 0; i < 16; i++) begin litQ.push_back(8'hFA); litQ.push_back(8'hBC); end
    checkRec("copy16");

    setCopy(0, 2, 'h123, 0); setLit(1, 'h55, 1);
    runStream(2, 1, 0);
    litQ = '{8'h01, 8'h00, 8'h21, 8'h23, 8'h55};
    checkRec("copy_lit_stall");

    for (int t = 0; t < 6; t++) begin
      n = $urandom_range(1, 40);
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 1) == 1) setCopy(i, $urandom_range(0, 15), $urandom_range(0, 4095), i == n - 1);
        else setLit(i, $urandom_range(0, 255), i == n - 1);
      end
      runStream(n, 1, 2);
    end

    // Reset during DATA: stall on the second data byte, then pulse rst_n.
    checkEn = 1'b0;
    readyModeG = 2;
    out_ready = 1'b0;
    setLit(0, 'h11, 0); setLit(1, 'h22, 0); setLit(2, 'h33, 1);
    for (int i = 0; i < 3; i++) sendItem(i, 0);
    guard = 0;
    while (!out_valid && guard < 50) begin @(negedge clk); guard++; end
    check("rst_setup_valid", int'(out_valid), 1);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("rst_setup_byte", int'(out_byte), 'h22);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", int'(out_valid), 0);
    check("midrst_out_byte", int'(out_byte), 0);
    check("midrst_out_last", int'(out_last), 0);
    check("midrst_item_ready", int'(item_ready), 0);
    check("midrst_done", int'(done), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    expByteQ.delete();
    expLastQ.delete();
    checkEn = 1'b1;
    @(posedge clk);
    #1;
    setLit(0, 'h7E, 1);
    runStream(1, 0, 0);
    litQ = '{8'h00, 8'h00, 8'h7E};
    checkRec("after_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/compressed_stream_packer.md
# compressed_stream_packer

Downstream stage of the compressor core. It accepts one compressed item per handshake: a literal byte or a copy of 4-bit length code plus 12-bit offset. It buffers items into groups of up to GROUP_ITEMS, builds each group's 16-bit control word, and emits the group as a byte stream in LZRW1 order: control word low byte, control word high byte, then the item bytes. This turns the core's per-item results into a serial output a host or memory writer can consume under backpressure.

## Interface
- GROUP_ITEMS, 16, items per group; legal range 1..16; unused control-word bits are 0

- clock  in  1  single clock; all logic on rising edge
- reset  in  1  asynchronous, active-low; clears all state
- item_valid  in  1  an item is presented
- item_ready  out  1  packer accepts the item this cycle
- item_is_copy  in  1  1 = copy item, 0 = literal
- item_literal  in  8  literal byte (ignored for copy)
- item_length  in  4  encoded copy length (match length minus 3), passed through unmodified
- item_offset  in  12  copy offset (ignored for literal)
- item_last  in  1  final item of the stream; closes the current group
- out_valid  out  1  out_byte is valid
- out_ready  in  1  consumer accepts out_byte
- out_byte  out  8  packed output byte
- out_last  out  1  with out_valid: final byte of the stream
- done  out  1  one-cycle pulse after the out_last byte is accepted

## Operation
- States: IDLE → COLLECT → CW_LO → CW_HI → DATA → COLLECT, or → IDLE via done.
- IDLE: entered from reset; moves to COLLECT on the next edge unconditionally.
- COLLECT: item_ready=1. On accept, store entry {is_copy, b0, b1} at index item_cnt:
  - Literal: b0 = item_literal.
  - Copy: b0 = {item_length, item_offset[11:8]}, b1 = item_offset[7:0].
  - Set cw[item_cnt] = item_is_copy, then item_cnt++.
- Group closes on the accept that makes item_cnt == GROUP_ITEMS, or on the accept of an item with item_last=1. The next state is CW_LO and the last_grp flag latches item_last.
- CW_LO: out_byte = cw[7:0]. CW_HI: out_byte = cw[15:8]. Each state advances only on out_valid && out_ready.
- DATA: walk entries 0..item_cnt-1.
  - Literal entry: emits b0 only.
  - Copy entry: emits b0, then b1, tracked by a half-select bit.
- out_last = last_grp and the current byte is the final byte of the final entry.
- On acceptance of the final byte:
  - Clear cw, item_cnt, pointers.
  - If last_grp: pulse done, return to IDLE. Otherwise go to COLLECT.
- item_ready=0 in every state except COLLECT. Items are never dropped: a held item_valid waits.
- Widths: item_cnt 5 bits (0..16), rd_idx 4 bits, half 1 bit, cw 16 bits.
- Bytes per group = 2 + literals + 2×copies, max 34.

## Timing
- Reset values:
  - item_ready=0, out_valid=0, out_byte=0, out_last=0, done=0.
  - cw=0, item_cnt=0, state IDLE.
- item_ready rises on the first clock edge after reset deasserts.
- Accept of the closing item at edge N: out_valid=1 with cw[7:0] after edge N; item_ready=0 after edge N.
- All outputs are registered. The output is stable while out_valid && !out_ready. With out_ready held high, one byte transfers per cycle, with no bubbles between the CW and DATA states.
- done is high for exactly one cycle, after the edge that accepts the out_last byte.
- Reset asserted mid-group or mid-emission: the buffered group is discarded, and all outputs take reset values immediately (asynchronous).
- item_last together with the GROUP_ITEMS-th item: a single close, and last_grp=1.
- An empty stream (no items) produces no output and no done.

## Structure
- Package lzrw1_pkg:
  - Typedef packed item struct {is_copy, literal, length[3:0], offset[11:0]}.
  - State enum.
  - CW_BITS=16 and MAX_GROUP=16 constants.
- Sub-module group_buffer: a 16-entry register file of {is_copy, b0, b1}, with one write port (write enable + index) and a combinational read by index.
- The top holds the FSM, the counters and the output registers.

## Test plan
- Literals 0x41, 0x42, 0x43, last on 0x43, out_ready=1 → bytes 00 00 41 42 43; out_last on 43; done one cycle later.
- Copy (length 2, offset 0x123), then literal 0x55 with last → bytes 01 00 21 23 55.
- 17 literals 0x00..0x10, last on the 17th → 00 00 00..0F, then 00 00 10. item_ready is low during the first emission; out_last only on 10.
- 16 copies (length 0xF, offset 0xABC), last on the 16th → FF FF, then 16 × (FA BC); 34 bytes total.
- Random out_ready toggling on the second test → identical byte sequence, and out_byte stable whenever the consumer stalls.
- Reset pulse asserted during DATA → outputs cleared; after release, a fresh 1-literal stream 0x7E gives 00 00 7E.
